// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared PC-source codes and fetch-stage defaults
package if_stage_pkg;
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0000;
  localparam int          IMEM_WORDS_DEF = 64;
endpackage

// File: rtl/if_stage_pc_reg.sv
// if_stage_pc_reg: program counter register with load enable
//  clk, rst (async, active-high) ; en: load d ; d: next pc ; pc_q: current pc
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] pc_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else if (en) pc_q <= d;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC, IF/ID register and fetch counter
//  in : clk, rst, stall, flush, pcsrc[1:0], branch_target, jump_index[25:0],
//       jr_target, imem_inst (combinational ROM data for imem_addr)
//  out: imem_addr (= pc), id_inst, id_pc4, id_valid, fetch_oob, fetch_count
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        fetch_oob,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_q, pc_d, pc4, target;
  logic [31:0] id_inst_q, id_inst_d, id_pc4_q, id_pc4_d, fetch_count_q, fetch_count_d;
  logic        id_valid_q, id_valid_d, pc_en, redirect, bubble, load;
  if_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .en   (pc_en),
    .d    (pc_d),
    .pc_q (pc_q)
  );
  // A redirect drops the word fetched this cycle (no delay slot) and overrides stall.
  always_comb begin
    redirect      = pcsrc != PCSRC_SEQ;
    bubble        = redirect | flush;
    load          = ~bubble & ~stall;
    pc4           = pc_q + 32'd4;
    target        = pcsrc == PCSRC_BR ? branch_target :
                    pcsrc == PCSRC_J  ? {id_pc4_q[31:28], jump_index, 2'b00} : jr_target;
    pc_en         = redirect | ~stall;
    pc_d          = redirect ? (target & 32'hFFFF_FFFC) : pc4;
    id_inst_d     = bubble ? NOP_INST : load ? imem_inst : id_inst_q;
    id_pc4_d      = load ? pc4 : id_pc4_q;
    id_valid_d    = load ? 1'b1 : bubble ? 1'b0 : id_valid_q;
    fetch_count_d = fetch_count_q + 32'(load);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_inst_q     <= NOP_INST;
      id_pc4_q      <= 32'd0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      id_inst_q     <= id_inst_d;
      id_pc4_q      <= id_pc4_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  assign imem_addr   = pc_q;
  assign id_inst     = id_inst_q;
  assign id_pc4      = id_pc4_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;
  assign fetch_oob   = pc_q >= 32'(4 * IMEM_WORDS);
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus randomized check of if_stage against a behavioural model
module tb_if_stage;
  logic        clk = 1'b0, rst = 1'b0, stall, flush, id_valid, fetch_oob;
  logic [1:0]  pcsrc;
  logic [25:0] jump_index;
  logic [31:0] branch_target, jr_target, imem_addr, imem_inst, id_inst, id_pc4, fetch_count;
  logic [31:0] rom [64];
  int          checks = 0, errors = 0;
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid;
  assign imem_inst = rom[imem_addr[7:2]];
  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .id_inst       (id_inst),
    .id_pc4        (id_pc4),
    .id_valid      (id_valid),
    .fetch_oob     (fetch_oob),
    .fetch_count   (fetch_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic compare_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".id_inst"}, id_inst, m_inst);
    chk({tag, ".id_pc4"}, id_pc4, m_pc4);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ".fetch_oob"}, {31'd0, fetch_oob}, {31'd0, m_pc >= 32'd256});
    chk({tag, ".fetch_count"}, fetch_count, m_cnt);
  endtask
  task automatic model_reset;
    m_pc = 32'd0; m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
  endtask
  task automatic drive(input logic s, input logic f, input logic [1:0] p,
                       input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jt);
    stall = s; flush = f; pcsrc = p; branch_target = bt; jump_index = ji; jr_target = jt;
  endtask
  // One clock: predict from the rules using current inputs, advance, then compare.
  task automatic cyc(input string tag);
    logic [31:0] tgt, fetched;
    fetched = rom[(m_pc / 4) % 64];
    case (pcsrc)
      2'd1:    tgt = branch_target;
      2'd2:    tgt = (m_pc4 & 32'hF000_0000) + {4'd0, jump_index, 2'd0};
      2'd3:    tgt = jr_target;
      default: tgt = 32'd0;
    endcase
    tgt = tgt - (tgt % 4);
    @(posedge clk);
    #1;
    if (pcsrc != 2'd0) begin
      m_pc = tgt; m_inst = 32'd0; m_valid = 1'b0;
    end else if (flush) begin
      if (!stall) m_pc = m_pc + 32'd4;
      m_inst = 32'd0; m_valid = 1'b0;
    end else if (!stall) begin
      m_inst = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      m_pc = m_pc + 32'd4;
    end
    compare_all(tag);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'hAAAA_0001; rom[1] = 32'hBBBB_0002; rom[2] = 32'hCCCC_0003; rom[3] = 32'hDDDD_0004;
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    #1 rst = 1'b1;
    #1 model_reset();
    compare_all("reset.async");
    @(posedge clk);
    #1 compare_all("reset.held");
    rst = 1'b0;
    cyc("t1.c1");
    cyc("t1.c2");
    chk("t1.pc8", imem_addr, 32'h8);
    chk("t1.inst_b", id_inst, 32'hBBBB_0002);
    chk("t1.cnt2", fetch_count, 32'd2);
    drive(1, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("t2.s1");
    cyc("t2.s2");
    chk("t2.pc_hold", imem_addr, 32'h8);
    chk("t2.pc4_hold", id_pc4, 32'h8);
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("t2.resume");
    chk("t2.inst_c", id_inst, 32'hCCCC_0003);
    drive(0, 0, 2'd1, 32'h20, 26'd0, 32'd0);
    cyc("t3.br");
    chk("t3.pc20", imem_addr, 32'h20);
    chk("t3.bubble", {31'd0, id_valid}, 32'd0);
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("t3.after");
    chk("t3.rom8", id_inst, rom[8]);
    chk("t3.pc4_24", id_pc4, 32'h24);
    drive(0, 0, 2'd2, 32'd0, 26'h000003, 32'd0);
    cyc("t4.j");
    chk("t4.pc_c", imem_addr, 32'hC);
    drive(0, 0, 2'd3, 32'd0, 26'd0, 32'h13);
    cyc("t4.jr");
    chk("t4.pc10", imem_addr, 32'h10);
    drive(1, 0, 2'd1, 32'h41, 26'd0, 32'd0);
    cyc("t4.br_stall");
    chk("t4.pc40", imem_addr, 32'h40);
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("fl.pre1");
    cyc("fl.pre2");
    drive(1, 1, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("fl.stall");
    chk("fl.stall_pc", imem_addr, 32'h48);
    drive(0, 1, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("fl.run");
    chk("fl.run_pc", imem_addr, 32'h4C);
    drive(0, 0, 2'd3, 32'd0, 26'd0, 32'hF0);
    cyc("t5.jr");
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    for (int i = 0; i < 3; i++) cyc("t5.run");
    chk("t5.pc_fc", imem_addr, 32'hFC);
    chk("t5.oob0", {31'd0, fetch_oob}, 32'd0);
    cyc("t5.cross");
    chk("t5.oob1", {31'd0, fetch_oob}, 32'd1);
    chk("t5.alias", imem_inst, 32'hAAAA_0001);
    cyc("t5.fetch_alias");
    chk("t5.alias_inst", id_inst, 32'hAAAA_0001);
    drive(0, 0, 2'd3, 32'd0, 26'd0, 32'hFFFF_FFFC);
    cyc("t5.jr_top");
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("t5.wrap");
    chk("t5.pc0", imem_addr, 32'h0);
    chk("t5.pc4_0", id_pc4, 32'h0);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] p;
      r = int'($urandom_range(0, 9));
      p = r < 6 ? 2'd0 : 2'(r - 6 + 1 > 3 ? 3 : r - 6 + 1);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, p,
            $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 32'h1FF)),
            $urandom_range(0, 3) == 0 ? 26'($urandom) : 26'($urandom_range(0, 127)),
            $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 32'h1FF)));
      cyc("rand");
    end
    drive(1, 0, 2'd1, 32'h80, 26'd0, 32'd0);
    #3 rst = 1'b1;
    #1 model_reset();
    compare_all("t6.async");
    @(posedge clk);
    #1 compare_all("t6.held");
    rst = 1'b0;
    drive(0, 0, 2'd0, 32'd0, 26'd0, 32'd0);
    cyc("t6.first");
    chk("t6.inst_a", id_inst, 32'hAAAA_0001);
    chk("t6.pc4", id_pc4, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
